// File: rtl/writeback_pkg.sv
// Shared definitions for the register-file writeback path.
//   wb_beat_t   : one writeback beat (destination address + data) at the
//                 default 5-bit address / 64-bit data configuration
//   WB_SRC_*    : 1-bit encodings identifying the granted producer
//   STALL_CNT_W : width of the ALU starvation counter
package writeback_pkg;

  localparam int unsigned WB_ADDR_W   = 5;
  localparam int unsigned WB_DATA_W   = 64;
  localparam int unsigned STALL_CNT_W = 4;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_LSU = 1'b1;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_beat_t;

endpackage

// File: rtl/wb_priority_arbiter.sv
// Combinational grant logic for the writeback port.
// The LSU has fixed priority, except that an ALU which has been denied
// MAX_STALL cycles in a row is force-granted. Flush blocks every grant.
// Ports:
//   alu_valid, lsu_valid : producer valids
//   stall_cnt            : current ALU starvation count
//   flush                : synchronous flush, suppresses grants
//   grant                : a beat is accepted this cycle
//   grant_src            : which producer is granted (WB_SRC_ALU/WB_SRC_LSU)
module wb_priority_arbiter
  import writeback_pkg::*;
#(
  parameter int MAX_STALL = 4
) (
  input  logic                   alu_valid,
  input  logic                   lsu_valid,
  input  logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   flush,
  output logic                   grant,
  output logic                   grant_src
);

  logic force_alu;

  assign force_alu = (stall_cnt == STALL_CNT_W'(MAX_STALL)) && alu_valid;

  always_comb begin
    grant     = 1'b0;
    grant_src = WB_SRC_LSU;
    if (!flush) begin
      if (force_alu) begin
        grant     = 1'b1;
        grant_src = WB_SRC_ALU;
      end else if (lsu_valid) begin
        grant     = 1'b1;
        grant_src = WB_SRC_LSU;
      end else if (alu_valid) begin
        grant     = 1'b1;
        grant_src = WB_SRC_ALU;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter driving the register file's single write port.
// Arbitrates ALU results and LSU load returns (LSU priority, ALU
// starvation guard), registers the winning beat for a one-cycle-latency
// write. Writes to x0 are consumed but never raise o_write_en.
// Ports:
//   clk, arst                        : clock, async active-high reset
//   i_flush                          : drop this cycle's grant, clear counter
//   i_alu_valid/addr/data, o_alu_ready : ALU producer handshake
//   i_lsu_valid/addr/data, o_lsu_ready : LSU producer handshake
//   o_write_en/addr/data             : register file write port
//   o_stall_cnt                      : current ALU starvation count
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_STALL  = 4
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   i_flush,
  input  logic                   i_alu_valid,
  input  logic [ADDR_WIDTH-1:0]  i_alu_addr,
  input  logic [DATA_WIDTH-1:0]  i_alu_data,
  output logic                   o_alu_ready,
  input  logic                   i_lsu_valid,
  input  logic [ADDR_WIDTH-1:0]  i_lsu_addr,
  input  logic [DATA_WIDTH-1:0]  i_lsu_data,
  output logic                   o_lsu_ready,
  output logic                   o_write_en,
  output logic [ADDR_WIDTH-1:0]  o_write_addr,
  output logic [DATA_WIDTH-1:0]  o_write_data,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  logic                   grant;
  logic                   grant_src;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  wb_priority_arbiter #(
    .MAX_STALL (MAX_STALL)
  ) u_arb (
    .alu_valid (i_alu_valid),
    .lsu_valid (i_lsu_valid),
    .stall_cnt (stall_cnt_q),
    .flush     (i_flush),
    .grant     (grant),
    .grant_src (grant_src)
  );

  assign o_alu_ready = grant && (grant_src == WB_SRC_ALU);
  assign o_lsu_ready = grant && (grant_src == WB_SRC_LSU);

  always_comb begin
    sel_addr = i_lsu_addr;
    sel_data = i_lsu_data;
    if (grant_src == WB_SRC_ALU) begin
      sel_addr = i_alu_addr;
      sel_data = i_alu_data;
    end
  end

  // Starvation counter: counts consecutive cycles the ALU is valid but denied.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt_q <= '0;
    end else if (i_flush || !i_alu_valid || o_alu_ready) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_q != STALL_CNT_W'(MAX_STALL)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;

  // Address/data hold when idle; only the enable drops.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      o_write_en   <= 1'b0;
      o_write_addr <= '0;
      o_write_data <= '0;
    end else if (grant) begin
      o_write_en   <= (sel_addr != '0);
      o_write_addr <= sel_addr;
      o_write_data <= sel_data;
    end else begin
      o_write_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  localparam int MAX_STALL = 4;

  logic        clk = 1'b0;
  logic        arst;
  logic        i_flush;
  logic        i_alu_valid;
  logic [4:0]  i_alu_addr;
  logic [63:0] i_alu_data;
  logic        o_alu_ready;
  logic        i_lsu_valid;
  logic [4:0]  i_lsu_addr;
  logic [63:0] i_lsu_data;
  logic        o_lsu_ready;
  logic        o_write_en;
  logic [4:0]  o_write_addr;
  logic [63:0] o_write_data;
  logic [3:0]  o_stall_cnt;

  writeback_arbiter #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (5),
    .MAX_STALL  (MAX_STALL)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .i_flush      (i_flush),
    .i_alu_valid  (i_alu_valid),
    .i_alu_addr   (i_alu_addr),
    .i_alu_data   (i_alu_data),
    .o_alu_ready  (o_alu_ready),
    .i_lsu_valid  (i_lsu_valid),
    .i_lsu_addr   (i_lsu_addr),
    .i_lsu_data   (i_lsu_data),
    .o_lsu_ready  (o_lsu_ready),
    .o_write_en   (o_write_en),
    .o_write_addr (o_write_addr),
    .o_write_data (o_write_data),
    .o_stall_cnt  (o_stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: how many cycles in a row the ALU has waited,
  // and what the register-file port should currently show.
  int          m_wait;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [63:0] m_data;

  logic got_alu_rdy, got_lsu_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock cycle: drive inputs, check handshake, clock, check write port.
  task automatic step(input logic fl,
                      input logic av, input logic [4:0] aa, input logic [63:0] ad,
                      input logic lv, input logic [4:0] la, input logic [63:0] ld);
    bit take_alu, take_lsu;
    @(negedge clk);
    i_flush = fl;
    i_alu_valid = av; i_alu_addr = aa; i_alu_data = ad;
    i_lsu_valid = lv; i_lsu_addr = la; i_lsu_data = ld;
    #1;
    take_alu = 0;
    take_lsu = 0;
    if (!fl) begin
      if (av && m_wait >= MAX_STALL) take_alu = 1;
      else if (lv)                   take_lsu = 1;
      else if (av)                   take_alu = 1;
    end
    got_alu_rdy = o_alu_ready;
    got_lsu_rdy = o_lsu_ready;
    check("alu_ready", o_alu_ready, take_alu);
    check("lsu_ready", o_lsu_ready, take_lsu);
    check("stall_cnt", o_stall_cnt, m_wait);
    @(posedge clk);
    #1;
    if (take_alu) begin
      m_we = (aa != 0); m_addr = aa; m_data = ad;
    end else if (take_lsu) begin
      m_we = (la != 0); m_addr = la; m_data = ld;
    end else begin
      m_we = 1'b0;
    end
    if (fl || !av || take_alu) m_wait = 0;
    else m_wait = (m_wait + 1 > MAX_STALL) ? MAX_STALL : m_wait + 1;
    check("write_en", o_write_en, m_we);
    check("write_addr", o_write_addr, m_addr);
    check("write_data", o_write_data, m_data);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  initial begin
    arst = 1'b1;
    i_flush = 0; i_alu_valid = 0; i_alu_addr = 0; i_alu_data = 0;
    i_lsu_valid = 0; i_lsu_addr = 0; i_lsu_data = 0;
    model_reset();
    #12;
    check("rst_we", o_write_en, 1'b0);
    check("rst_addr", o_write_addr, 5'd0);
    check("rst_data", o_write_data, 64'd0);
    check("rst_cnt", o_stall_cnt, 4'd0);
    @(negedge clk);
    arst = 1'b0;

    // Reset mid-stream: LSU beat to x7 lands, then arst clears it at once.
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h77);
    check("pre_rst_addr", o_write_addr, 5'd7);
    #2 arst = 1'b1;
    #1;
    check("midrst_we", o_write_en, 1'b0);
    check("midrst_addr", o_write_addr, 5'd0);
    check("midrst_data", o_write_data, 64'd0);
    model_reset();
    @(negedge clk);
    arst = 1'b0;
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h77);
    check("post_rst_we", o_write_en, 1'b1);
    idle();

    // Single ALU beat, then the enable drops.
    step(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0);
    check("alu_we", o_write_en, 1'b1);
    check("alu_addr", o_write_addr, 5'd5);
    check("alu_data", o_write_data, 64'hDEAD_BEEF);
    idle();
    check("alu_we_drop", o_write_en, 1'b0);

    // x0 is accepted but not written.
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h1234);
    check("x0_ready", got_lsu_rdy, 1'b1);
    check("x0_we", o_write_en, 1'b0);

    // Both valid: LSU first, ALU (holding its beat) the cycle after.
    step(1'b0, 1'b1, 5'd4, 64'h44, 1'b1, 5'd3, 64'h33);
    check("prio_addr0", o_write_addr, 5'd3);
    step(1'b0, 1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'd0);
    check("prio_addr1", o_write_addr, 5'd4);
    idle();

    // Starvation: ALU forced on the 5th cycle, then LSU resumes.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i < 5), 5'd9, 64'h99, 1'b1, 5'd10 + 5'(i), 64'(i));
      check("starve_alu_rdy", got_alu_rdy, (i == 4));
      check("starve_lsu_rdy", got_lsu_rdy, (i != 4));
    end
    check("starve_cnt0", o_stall_cnt, 4'd0);
    idle();

    // Flush with both valid.
    step(1'b0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2);
    step(1'b1, 1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2);
    check("flush_alu_rdy", got_alu_rdy, 1'b0);
    check("flush_lsu_rdy", got_lsu_rdy, 1'b0);
    check("flush_we", o_write_en, 1'b0);
    check("flush_cnt", o_stall_cnt, 4'd0);
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ra, rl;
      ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rl = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step(($urandom_range(0, 11) == 0),
           ($urandom_range(0, 3) != 0), ra, {$urandom, $urandom},
           ($urandom_range(0, 3) != 0), rl, {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Sits directly upstream of the register file and drives its single write port (write enable, write address, write data).
- Arbitrates between two producers, the ALU result path and the load/store unit (LSU) load-return path, using valid/ready handshakes.
- LSU has fixed priority. A starvation counter guarantees ALU forward progress.
- Output is fully registered: one write per cycle, one-cycle latency. Writes to x0 are accepted but never asserted to the register file.

Parameters:
- DATA_WIDTH, 64, width of write data.
- ADDR_WIDTH, 5, register address width.
- MAX_STALL, 4, consecutive ALU-denied cycles before the ALU is force-granted (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous flush; discards the registered beat and clears the starvation counter.
- i_alu_valid  in  1  ALU beat valid.
- i_alu_addr  in  ADDR_WIDTH  ALU destination register.
- i_alu_data  in  DATA_WIDTH  ALU result.
- o_alu_ready  out  1  ALU beat accepted this cycle.
- i_lsu_valid  in  1  LSU beat valid.
- i_lsu_addr  in  ADDR_WIDTH  LSU destination register.
- i_lsu_data  in  DATA_WIDTH  load data, already extended to DATA_WIDTH.
- o_lsu_ready  out  1  LSU beat accepted this cycle.
- o_write_en  out  1  to register file write_en_3.
- o_write_addr  out  ADDR_WIDTH  to register file i_addr_3.
- o_write_data  out  DATA_WIDTH  to register file i_write_data_3.
- o_stall_cnt  out  4  current starvation count (debug/coverage).

Behaviour:
- Clocking and reset: one clock (clk); asynchronous, active-high reset (arst).
- Values on arst: o_write_en=0, o_write_addr=0, o_write_data=0, stall counter=0. Reset asserted mid-transfer drops the in-flight beat.
- Ready signals are combinational from the valids and the stall counter. No ready-to-valid dependency: producers must not gate valid on ready.
- Grant rule, evaluated each cycle:
  - force = (stall_cnt == MAX_STALL) && i_alu_valid.
  - If force: grant ALU.
  - Else if i_lsu_valid: grant LSU.
  - Else if i_alu_valid: grant ALU.
  - Else: no grant.
- i_flush=1: both readies are 0 and no grant occurs.
- Accepted beat: the granted source's ready=1 in that cycle; the beat is transferred when valid && ready at the clock edge.
- Output register, on the edge after a grant:
  - o_write_addr and o_write_data are loaded from the granted source.
  - o_write_en = 1 only if the granted addr != 0.
  - A write to x0 is consumed silently: o_write_en=0, addr/data still loaded.
- With no grant or with flush, o_write_en=0 next cycle. o_write_addr and o_write_data hold their previous values.
- Latency: exactly 1 cycle from acceptance to the o_write_en pulse. Throughput is 1 beat/cycle; the register file never back-pressures.
- Starvation counter:
  - Clears on reset, on flush, whenever the ALU is granted, and whenever i_alu_valid=0.
  - Increments by 1 when i_alu_valid=1 and the ALU is not granted.
  - Saturates at MAX_STALL. Never wraps.
- Simultaneous valids with force active: the ALU is granted, the LSU sees o_lsu_ready=0 and must hold its beat. The counter clears.
- Both sources writing the same address in consecutive cycles: order of acceptance is order of register-file writes. Last write wins.
- Same-address read-after-write forwarding is not provided. The consumer of the register-file read ports handles it.

Decomposition:
- Shared package writeback_pkg holds:
  - typedef wb_beat_t (packed struct: addr, data).
  - localparam WB_SRC_ALU, WB_SRC_LSU (1-bit source encodings).
  - localparam STALL_CNT_W = 4.
- One natural sub-module: wb_priority_arbiter. It is combinational and contains the grant logic plus force override; its inputs are the two valids, stall_cnt and flush.
- Counter and output register stay in the top.

Test Plan:
1. Reset: assert arst mid-stream with i_lsu_valid=1, addr=7 -> all outputs 0 immediately. After release, the first grant appears on o_write_en one cycle after acceptance.
2. Single ALU beat: addr=5, data=64'hDEAD_BEEF -> next cycle o_write_en=1, o_write_addr=5, o_write_data=64'hDEAD_BEEF. The cycle after, o_write_en=0.
3. x0 discard: LSU beat addr=0, data=64'h1234 -> o_lsu_ready=1, next cycle o_write_en=0.
4. Priority: both valid in the same cycle (LSU addr=3, ALU addr=4) -> LSU granted. Register-file writes: addr 3, then addr 4 one cycle later.
5. Starvation: LSU valid continuously, ALU valid holding addr=9 -> o_alu_ready=1 on the 5th cycle (stall_cnt 0,1,2,3,4, then force). The LSU is stalled for exactly that one cycle, and o_stall_cnt returns to 0.
6. Flush: i_flush=1 with both valid -> both readies 0, next cycle o_write_en=0, o_stall_cnt=0.
